// File: rtl/rotate_seq_ctrl.sv
// rtl/rotate_seq_ctrl.sv - sequencing controller for an external right-rotate register
module rotate_seq_ctrl #(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [AW-1:0] in_amt,
    output logic          rr_load,
    output logic          rr_en,
    output logic [DW-1:0] rr_data,
    input  logic [DW-1:0] rr_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ROT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_data;

    // Request capture, enable-cycle countdown and state sequencing
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_cnt   <= in_amt;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // A zero amount skips ROT so no enable pulse is issued
                    r_state <= (r_cnt != '0) ? S_ROT : S_DONE;
                end
                S_ROT: begin
                    // Only entered with r_cnt >= 1, so this never wraps
                    r_cnt <= r_cnt - AW'(1);
                    if (r_cnt == AW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state only; reset masks acceptance
    assign in_ready  = (r_state == S_IDLE) && !sync_rst;
    assign rr_load   = (r_state == S_LOAD);
    assign rr_en     = (r_state == S_ROT);
    assign rr_data   = r_data;
    assign out_valid = (r_state == S_DONE);
    assign out_data  = rr_q;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// tb/tb_rotate_seq_ctrl.sv - scoreboard bench for rotate_seq_ctrl with a rotate-register model
module tb_rotate_seq_ctrl;

    localparam int DW = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          sync_rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_amt;
    logic          rr_load;
    logic          rr_en;
    logic [DW-1:0] rr_data;
    logic [DW-1:0] rr_q;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rotate_seq_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .rr_load   (rr_load),
        .rr_en     (rr_en),
        .rr_data   (rr_data),
        .rr_q      (rr_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // External right-rotate register: load has priority over en
    always_ff @(posedge clk) begin
        if (sync_rst)     rr_q <= '0;
        else if (rr_load) rr_q <= rr_data;
        else if (rr_en)   rr_q <= {rr_q[0], rr_q[DW-1:1]};
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: rotate right by amt mod DW, via a doubled word
    function automatic logic [DW-1:0] rot_ref(input logic [DW-1:0] d, input int amt);
        logic [2*DW-1:0] dd;
        int k;
        k  = amt % DW;
        dd = {d, d} >> k;
        return dd[DW-1:0];
    endfunction

    typedef struct {
        logic [DW-1:0] d;
        int            amt;
    } exp_t;

    exp_t exp_q[$];

    // Monitor state: cycles (negedges) since the accept, enable pulses seen
    bit active     = 1'b0;
    bit seen_valid = 1'b0;
    bit rst_prev   = 1'b0;
    bit started    = 1'b0;
    int cyc        = 0;
    int en_cnt     = 0;

    always @(negedge clk) begin
        if (sync_rst) begin
            chk("in_ready_in_reset", int'(in_ready), 0);
            if (rst_prev) begin
                chk("busy_in_reset", int'(busy), 0);
                chk("out_valid_in_reset", int'(out_valid), 0);
                chk("rr_q_in_reset", int'(rr_q), 0);
            end
            exp_q.delete();
            active     = 1'b0;
            seen_valid = 1'b0;
            started    = 1'b1;
        end else if (started) begin
            if (rr_load && rr_en) chk("load_en_overlap", 1, 0);
            if (active) begin
                cyc++;
                if (rr_en) en_cnt++;
                if (cyc == 1) chk("load_after_accept", int'(rr_load), 1);
                chk("busy_active", int'(busy), 1);
                chk("in_ready_active", int'(in_ready), 0);
            end else begin
                chk("idle_busy", int'(busy), 0);
                chk("idle_in_ready", int'(in_ready), 1);
                chk("idle_out_valid", int'(out_valid), 0);
                chk("idle_rr_en", int'(rr_en), 0);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    if (!seen_valid) begin
                        // first out_valid sample lands amt+2 negedges after the accept sample
                        chk("latency", cyc, exp_q[0].amt + 2);
                        chk("en_pulses", en_cnt, exp_q[0].amt);
                        seen_valid = 1'b1;
                    end
                    chk("out_data", int'(out_data), int'(exp_q[0].d));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen_valid = 1'b0;
                        active     = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.d   = rot_ref(in_data, int'(in_amt));
                e.amt = int'(in_amt);
                if (exp_q.size() != 0) chk("accept_while_outstanding", 1, 0);
                exp_q.push_back(e);
                active     = 1'b1;
                seen_valid = 1'b0;
                cyc        = 0;
                en_cnt     = 0;
            end
        end
        rst_prev = sync_rst;
    end

    task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] a);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_amt   = AW'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) chk("idle_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        sync_rst  = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'b1111;
        in_amt    = 3'd2;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sync_rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", int'(in_ready), 1);
        chk("rr_data_after_reset", int'(rr_data), 0);
        chk("out_data_after_reset", int'(out_data), 0);
        @(posedge clk);
        #1;

        // Basic, wrap-around and zero-amount requests
        send(4'b1001, 3'd1); wait_idle();
        send(4'b0110, 3'd5); wait_idle();
        send(4'b0110, 3'd4); wait_idle();
        send(4'b1011, 3'd0); wait_idle();
        send(4'b1001, 3'd7); wait_idle();

        // Back-pressure with ignored input traffic
        out_ready = 1'b0;
        send(4'b1000, 3'd3);
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!out_valid && t < 50) begin
                t++;
                @(negedge clk);
            end
            if (t >= 50) chk("bp_valid_timeout", 1, 0);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            in_amt   = AW'($urandom);
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_data", int'(out_data), 4'b0001);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Back-to-back random requests with in_valid held high
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int t;
            in_data = DW'($urandom);
            in_amt  = AW'($urandom_range(0, 7));
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (t >= 200) chk("b2b_timeout", 1, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_idle();

        // Reset during the third enable cycle of an amt=7 request
        send(4'b1110, 3'd7);
        begin
            int t;
            int ens;
            t   = 0;
            ens = 0;
            while (ens < 2 && t < 50) begin
                @(negedge clk);
                if (rr_en) ens++;
                t++;
            end
            if (t >= 50) chk("mid_rst_timeout", 1, 0);
        end
        @(posedge clk);
        #1;
        sync_rst = 1'b1;
        @(posedge clk);
        #1;
        sync_rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_idle", int'(busy), 0);
        chk("mid_rst_rr_q", int'(rr_q), 0);
        chk("mid_rst_no_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        send(4'b0101, 3'd2); wait_idle();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
